// File: rtl/muldiv_sequencer_pkg.sv
// Shared funct codes and sequencer state encoding for the HI/LO multiply/divide unit.
package mips_muldiv_pkg;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1A;
  localparam logic [5:0] FN_DIVU  = 6'h1B;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } state_t;

  function automatic logic is_muldiv_fn(input logic [5:0] fn);
    return (fn == FN_MULT) || (fn == FN_MULTU) || (fn == FN_DIV) || (fn == FN_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_iter_core.sv
// One iteration of unsigned shift-add multiply or restoring divide on the {acc_hi,acc_lo} pair.
module muldiv_iter_core #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] nxt_hi,
  output logic [WIDTH-1:0] nxt_lo
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] diff;

  // Any rem_sh at or above 2**WIDTH is necessarily >= divisor, so the WIDTH-bit difference is exact.
  always_comb begin
    sum    = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
    rem_sh = {acc_hi, acc_lo[WIDTH-1]};
    diff   = rem_sh[WIDTH-1:0] - operand;
    if (is_div) begin
      if (rem_sh >= {1'b0, operand}) begin
        nxt_hi = diff;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh[WIDTH-1:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = sum[WIDTH:1];
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// MIPS mult/multu/div/divu sequencer: owns HI/LO, runs WIDTH iterations on magnitudes, then sign-fixes.
module muldiv_sequencer
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] rd_data,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   acc_lo;
  logic [WIDTH-1:0]   operand;
  logic               op_div;
  logic               res_neg;
  logic               rem_neg;

  logic               op_signed;
  logic               rs_neg;
  logic               rt_neg;
  logic [WIDTH-1:0]   rs_mag;
  logic [WIDTH-1:0]   rt_mag;
  logic               accept;
  logic [WIDTH-1:0]   nxt_hi;
  logic [WIDTH-1:0]   nxt_lo;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;

  // Iteration always works on magnitudes; signs are reapplied in the FIX cycle.
  assign op_signed = (funct == FN_MULT) || (funct == FN_DIV);
  assign rs_neg    = op_signed & rs_val[WIDTH-1];
  assign rt_neg    = op_signed & rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? -rs_val : rs_val;
  assign rt_mag    = rt_neg ? -rt_val : rt_val;
  assign accept    = start && (state == ST_IDLE) && is_muldiv_fn(funct);

  assign stall     = start & busy;

  assign prod_fix  = res_neg ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
  assign quo_fix   = res_neg ? -acc_lo : acc_lo;
  assign rem_fix   = rem_neg ? -acc_hi : acc_hi;

  always_comb begin
    rd_data = '0;
    if (funct == FN_MFHI) begin
      rd_data = hi;
    end else if (funct == FN_MFLO) begin
      rd_data = lo;
    end
  end

  muldiv_iter_core #(.WIDTH(WIDTH)) u_core (
    .is_div  (state == ST_DIV),
    .acc_hi  (acc_hi),
    .acc_lo  (acc_lo),
    .operand (operand),
    .nxt_hi  (nxt_hi),
    .nxt_lo  (nxt_lo)
  );

  // Multiply loads the multiplier into acc_lo; divide loads the dividend there and the divisor as operand.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      op_div  <= 1'b0;
      res_neg <= 1'b0;
      rem_neg <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            op_div  <= funct[1];
            res_neg <= rs_neg ^ rt_neg;
            rem_neg <= rs_neg;
            acc_hi  <= '0;
            acc_lo  <= funct[1] ? rs_mag : rt_mag;
            operand <= funct[1] ? rt_mag : rs_mag;
            count   <= CNT_W'(WIDTH);
            busy    <= 1'b1;
            state   <= funct[1] ? ST_DIV : ST_MUL;
          end else if (start && (funct == FN_MTHI)) begin
            hi <= rs_val;
          end else if (start && (funct == FN_MTLO)) begin
            lo <= rs_val;
          end
        end
        ST_MUL, ST_DIV: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          count  <= count - CNT_W'(1);
          if (count == CNT_W'(1)) begin
            state <= ST_FIX;
          end
        end
        ST_FIX: begin
          if (op_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            {hi, lo} <= prod_fix;
          end
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed and randomized checks of muldiv_sequencer against an arithmetic HI/LO model.
module tb_muldiv_sequencer;
  import mips_muldiv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [5:0]  funct;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] rd_data;
  logic [31:0] hi;
  logic [31:0] lo;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .funct   (funct),
    .rs_val  (rs_val),
    .rt_val  (rt_val),
    .busy    (busy),
    .stall   (stall),
    .done    (done),
    .rd_data (rd_data),
    .hi      (hi),
    .lo      (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Returns {hi,lo} as the MIPS instruction defines it, using whole-number arithmetic.
  function automatic logic [63:0] model(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint      sp;
    logic [31:0] ua, ub, q, r;
    logic        sa, sb;
    p = '0;
    if (fn == FN_MULT) begin
      sp = longint'($signed(a)) * longint'($signed(b));
      p  = sp;
    end else if (fn == FN_MULTU) begin
      p = {32'b0, a} * {32'b0, b};
    end else begin
      sa = (fn == FN_DIV) && a[31];
      sb = (fn == FN_DIV) && b[31];
      ua = sa ? -a : a;
      ub = sb ? -b : b;
      if (ub == 0) begin
        q = 32'hFFFFFFFF;
        r = ua;
      end else begin
        q = ua / ub;
        r = ua % ub;
      end
      if (sa ^ sb) q = -q;
      if (sa) r = -r;
      p = {r, q};
    end
    return p;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issues one multiply/divide, scrambles the operand buses while busy, and checks the result.
  task automatic applyStimulus(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] exp;
    int          cycles;
    exp    = model(fn, a, b);
    start  = 1'b1;
    funct  = fn;
    rs_val = a;
    rt_val = b;
    #1;
    checkOutput("accept_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start  = 1'b0;
    rs_val = $urandom;
    rt_val = $urandom;
    #1;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      cycles++;
      @(negedge clk);
      #1;
    end
    checkOutput("busy_cycles", 64'(cycles), 64'd33);
    checkOutput("done_pulse", 64'(done), 64'd1);
    m_hi = exp[63:32];
    m_lo = exp[31:0];
    checkOutput("hi", 64'(hi), 64'(m_hi));
    checkOutput("lo", 64'(lo), 64'(m_lo));
  endtask

  initial begin
    logic [5:0]  fns [4];
    logic [5:0]  fn;
    logic [31:0] a, b, v;
    logic        bad;
    int          cycles;

    fns[0] = FN_MULT;
    fns[1] = FN_MULTU;
    fns[2] = FN_DIV;
    fns[3] = FN_DIVU;

    reset  = 1'b1;
    start  = 1'b0;
    funct  = 6'h00;
    rs_val = '0;
    rt_val = '0;
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    checkOutput("reset_stall", 64'(stall), 64'd0);
    reset = 1'b0;

    // mthi / mtlo are single-cycle writes
    @(negedge clk);
    start = 1'b1; funct = FN_MTHI; rs_val = 32'h0000_1234;
    @(negedge clk);
    #1;
    checkOutput("mthi", 64'(hi), 64'h1234);
    checkOutput("mthi_busy", 64'(busy), 64'd0);
    checkOutput("mthi_done", 64'(done), 64'd0);
    v = $urandom;
    funct = FN_MTLO; rs_val = v;
    @(negedge clk);
    #1;
    checkOutput("mtlo", 64'(lo), 64'(v));
    funct = FN_MFHI;
    #1;
    checkOutput("mfhi_rd", 64'(rd_data), 64'h1234);
    funct = FN_MFLO;
    #1;
    checkOutput("mflo_rd", 64'(rd_data), 64'(v));
    checkOutput("mflo_stall", 64'(stall), 64'd0);

    // funct codes outside the set are ignored
    funct = 6'h15;
    #1;
    checkOutput("bad_fn_stall", 64'(stall), 64'd0);
    checkOutput("bad_fn_rd", 64'(rd_data), 64'd0);
    @(negedge clk);
    funct = 6'h20;
    #1;
    checkOutput("bad_fn_busy", 64'(busy), 64'd0);
    @(negedge clk);
    start = 1'b0;

    applyStimulus(FN_MULT, 32'd7, 32'hFFFF_FFFD);
    checkOutput("mult_7_m3", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    @(negedge clk);
    #1;
    checkOutput("done_one_cycle", 64'(done), 64'd0);

    applyStimulus(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    checkOutput("multu_max", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    applyStimulus(FN_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("div_m7_2", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    applyStimulus(FN_DIVU, 32'd100, 32'd0);
    checkOutput("divu_by_zero", {hi, lo}, 64'h0000_0064_FFFF_FFFF);
    applyStimulus(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("div_min_m1", {hi, lo}, 64'h0000_0000_8000_0000);
    applyStimulus(FN_DIV, 32'hFFFF_FFF9, 32'd0);

    // mflo presented mid-operation must stall until the result lands
    @(negedge clk);
    start = 1'b1; funct = FN_MULT; rs_val = 32'd12345; rt_val = 32'hFFFF_0000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1; funct = FN_MFLO;
    #1;
    bad = 1'b0;
    cycles = 0;
    while (busy === 1'b1 && cycles < 40) begin
      if (stall !== 1'b1) bad = 1'b1;
      cycles++;
      @(negedge clk);
      #1;
    end
    checkOutput("mflo_wait_stall", 64'(bad), 64'd0);
    checkOutput("mflo_wait_cycles", 64'(cycles), 64'd29);
    {m_hi, m_lo} = model(FN_MULT, 32'd12345, 32'hFFFF_0000);
    checkOutput("mflo_after_done", 64'(rd_data), 64'(m_lo));
    checkOutput("mflo_after_stall", 64'(stall), 64'd0);
    start = 1'b0;

    // reset in the middle of an iteration aborts without a done pulse
    @(negedge clk);
    start = 1'b1; funct = FN_MULTU; rs_val = $urandom; rt_val = $urandom;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1;
    reset = 1'b0;
    m_hi = '0;
    m_lo = '0;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_hilo", {hi, lo}, 64'd0);
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done !== 1'b0) bad = 1'b1;
    end
    checkOutput("abort_no_done", 64'(bad), 64'd0);
    #1;
    applyStimulus(FN_MULT, 32'hFFFF_FF00, 32'd300);

    // back-to-back: each applyStimulus starts in the previous done cycle
    applyStimulus(FN_DIVU, 32'hDEAD_BEEF, 32'd17);
    applyStimulus(FN_MULT, 32'h8000_0000, 32'h8000_0000);

    for (int i = 0; i < 16; i++) begin
      fn = fns[$urandom_range(0, 3)];
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(8, 31);
      applyStimulus(fn, a, b);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
